// File: rtl/ahb_lite_pkg.sv
// ahb_lite_pkg: AHB-Lite transfer/size/burst codes, command record layout and lane helpers.
// Shared by ahb_cmd_fifo and ahb_lite_cmd_master; no ports.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] HSIZE_BYTE    = 3'b000;
    localparam logic [2:0] HSIZE_HALF    = 3'b001;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR   = 3'b001;

    // Command record, 68 bits: {write, size, addr, wdata}
    localparam int CMD_W = 68;
    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } cmd_t;

    // Any size code of 010 or above is issued as a word
    function automatic logic [2:0] norm_size(input logic [2:0] s);
        return (s[2:1] != 2'b00) ? HSIZE_WORD : s;
    endfunction

    function automatic logic [31:0] align_addr(input logic [2:0] s, input logic [31:0] a);
        return (s == HSIZE_HALF) ? {a[31:1], 1'b0} : (s == HSIZE_WORD) ? {a[31:2], 2'b00} : a;
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] s, input logic [31:0] d);
        return (s == HSIZE_BYTE) ? {4{d[7:0]}} : (s == HSIZE_HALF) ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] lane_ext(input logic [2:0] s, input logic [1:0] a, input logic [31:0] d);
        return (s == HSIZE_BYTE) ? {24'd0, d[{a, 3'b000} +: 8]} :
               (s == HSIZE_HALF) ? {16'd0, d[{a[1], 4'b0000} +: 16]} : d;
    endfunction

endpackage

// File: rtl/ahb_cmd_fifo.sv
// ahb_cmd_fifo: synchronous command FIFO with registered full/empty flags.
// Ports: i_clk, i_rst (async, active-high), i_push/i_din write side, i_pop/o_dout read side
// (o_dout shows the head entry), o_full, o_empty. Push when full and pop when empty are ignored.
module ahb_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 68
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt, w_cnt_nxt;
    logic          r_full, r_empty, w_push, w_pop;

    assign w_push    = i_push & ~r_full;
    assign w_pop     = i_pop & ~r_empty;
    assign w_cnt_nxt = r_cnt + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    assign o_dout    = r_mem[r_rp];
    assign o_full    = r_full;
    assign o_empty   = r_empty;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            r_cnt   <= w_cnt_nxt;
            r_full  <= w_cnt_nxt == (AW+1)'(DEPTH);
            r_empty <= w_cnt_nxt == '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wp] <= i_din;
    end

endmodule

// File: rtl/ahb_lite_cmd_master.sv
// ahb_lite_cmd_master: pipelined AHB-Lite master fed by a buffered command stream.
// Ports: HCLK, HRESET (async, active-high); command in: cmd_valid/cmd_ready/cmd_write/cmd_addr/
// cmd_size/cmd_wdata; response out: rsp_valid/rsp_write/rsp_err/rsp_rdata; idle; AHB master
// outputs HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA (all registered); AHB inputs HRDATA/HREADY/HRESP.
// Optional macro AHB_MASTER_SEQ_EN: mark address-contiguous transfers as SEQ with HBURST=INCR.
module ahb_lite_cmd_master
    import ahb_lite_pkg::*;
#(
    parameter int CMD_DEPTH = 4
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_write,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        idle,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    cmd_t        w_cmd_in, w_head;
    logic        w_full, w_empty, w_pop, w_seq, w_done;
    logic [2:0]  w_size;
    logic [31:0] w_addr;

    // Address phase
    htrans_e     r_htrans;
    logic [31:0] r_haddr, r_a_wdata;
    logic        r_hwrite;
    logic [2:0]  r_hsize, r_hburst;
    // Data phase
    logic        r_d_valid, r_d_write;
    logic [2:0]  r_d_size;
    logic [1:0]  r_d_lsb;
    logic [31:0] r_hwdata;
    // Response
    logic        r_rsp_valid, r_rsp_write, r_rsp_err;
    logic [31:0] r_rsp_rdata;

    assign w_cmd_in = {cmd_write, cmd_size, cmd_addr, cmd_wdata};

    ahb_cmd_fifo #(.DEPTH(CMD_DEPTH), .W(CMD_W)) u_fifo (
        .i_clk   (HCLK),
        .i_rst   (HRESET),
        .i_push  (cmd_valid),
        .i_din   (w_cmd_in),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_pop  = HREADY & ~w_empty;
    assign w_size = norm_size(w_head.size);
    assign w_addr = align_addr(w_size, w_head.addr);
    assign w_done = r_d_valid & HREADY;

`ifdef AHB_MASTER_SEQ_EN
    localparam logic [2:0] BURST = HBURST_INCR;
    // Continuation of the previous active transfer; a 1 KB boundary forces NONSEQ
    assign w_seq = (r_htrans != HT_IDLE) && (r_hwrite == w_head.write) && (r_hsize == w_size) &&
                   (w_addr == r_haddr + (32'd1 << w_size)) && (w_addr[9:0] != 10'd0);
`else
    localparam logic [2:0] BURST = HBURST_SINGLE;
    assign w_seq = 1'b0;
`endif

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_htrans    <= HT_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= HSIZE_BYTE;
            r_hburst    <= HBURST_SINGLE;
            r_a_wdata   <= '0;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_size    <= HSIZE_BYTE;
            r_d_lsb     <= '0;
            r_hwdata    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            // Both pipeline stages advance together, only on HREADY
            if (HREADY) begin
                r_htrans <= w_pop ? (w_seq ? HT_SEQ : HT_NONSEQ) : HT_IDLE;
                if (w_pop) begin
                    r_haddr   <= w_addr;
                    r_hwrite  <= w_head.write;
                    r_hsize   <= w_size;
                    r_hburst  <= BURST;
                    r_a_wdata <= w_head.wdata;
                end
                r_d_valid <= r_htrans != HT_IDLE;
                r_d_write <= r_hwrite;
                r_d_size  <= r_hsize;
                r_d_lsb   <= r_haddr[1:0];
                if ((r_htrans != HT_IDLE) && r_hwrite) r_hwdata <= lane_rep(r_hsize, r_a_wdata);
            end
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_write <= r_d_write;
                r_rsp_err   <= HRESP;
                r_rsp_rdata <= r_d_write ? 32'd0 : lane_ext(r_d_size, r_d_lsb, HRDATA);
            end
        end
    end

    assign cmd_ready = ~w_full;
    assign idle      = w_empty & (r_htrans == HT_IDLE) & ~r_d_valid;
    assign HTRANS    = r_htrans;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = r_hsize;
    assign HBURST    = r_hburst;
    assign HWDATA    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_write = r_rsp_write;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// tb_ahb_lite_cmd_master: directed self-checking bench for ahb_lite_cmd_master.
module tb_ahb_lite_cmd_master;

    logic        HCLK = 1'b0, HRESET = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [2:0]  cmd_size = '0;
    logic        rsp_valid, rsp_write, rsp_err, idle;
    logic [31:0] rsp_rdata, HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE, HBURST;
    logic        HREADY = 1'b1, HRESP = 1'b0;

    logic        use_model = 1'b0;
    logic [31:0] hrdata_drv = '0;
    logic [31:0] s_addr = '0;
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic        w;
        logic        e;
        logic [31:0] d;
    } rsp_t;
    rsp_t q[$];

    ahb_lite_cmd_master #(.CMD_DEPTH(4)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .idle(idle), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    always #5 HCLK = ~HCLK;

    // Slave model: read data for a data phase is 0x5A000000 | its address
    always @(posedge HCLK) if (HREADY) s_addr <= HADDR;
    assign HRDATA = use_model ? (32'h5A00_0000 | s_addr) : hrdata_drv;

    always @(negedge HCLK) if (rsp_valid) q.push_back('{w: rsp_write, e: rsp_err, d: rsp_rdata});

    task automatic push(input logic w, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
        @(negedge HCLK);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge HCLK);
        n_chk++; if (HTRANS !== 2'b00) begin n_fail++; $display("FAIL rst_htrans got %h exp 0", HTRANS); end
        n_chk++; if (HADDR !== 32'd0) begin n_fail++; $display("FAIL rst_haddr got %h exp 0", HADDR); end
        n_chk++; if ({HWRITE, HSIZE, HBURST} !== 7'd0) begin n_fail++; $display("FAIL rst_ctrl got %b exp 0", {HWRITE, HSIZE, HBURST}); end
        n_chk++; if (HWDATA !== 32'd0) begin n_fail++; $display("FAIL rst_hwdata got %h exp 0", HWDATA); end
        n_chk++; if ({rsp_valid, rsp_write, rsp_err} !== 3'd0 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rsp got %b/%h exp 0", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
        n_chk++; if ({idle, cmd_ready} !== 2'b11) begin n_fail++; $display("FAIL rst_idle_ready got %b exp 11", {idle, cmd_ready}); end
        HRESET = 1'b0;
        @(negedge HCLK);
        n_chk++; if ({idle, cmd_ready, HTRANS} !== 4'b1100) begin n_fail++; $display("FAIL rst_after got %b exp 1100", {idle, cmd_ready, HTRANS}); end
    endtask

    task automatic test_word_wr_rd;
        use_model = 1'b0; hrdata_drv = 32'hDEAD_BEEF;
        push(1'b1, 32'h10, 3'b010, 32'hDEAD_BEEF);
        push(1'b0, 32'h10, 3'b010, 32'h0);
        n_chk++; if ({HTRANS, HWRITE} !== 3'b101 || HADDR !== 32'h10) begin n_fail++; $display("FAIL t1_wr_addr got %b %h exp 101 10", {HTRANS, HWRITE}, HADDR); end
        @(negedge HCLK);
        n_chk++; if (HWDATA !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_hwdata got %h exp deadbeef", HWDATA); end
        n_chk++; if ({HTRANS, HWRITE} !== 3'b100 || HADDR !== 32'h10) begin n_fail++; $display("FAIL t1_rd_addr got %b %h exp 100 10", {HTRANS, HWRITE}, HADDR); end
        @(negedge HCLK);
        n_chk++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b110 || rsp_rdata !== 32'd0) begin n_fail++; $display("FAIL t1_wr_rsp got %b %h exp 110 0", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
        @(negedge HCLK);
        n_chk++; if ({rsp_valid, rsp_write, rsp_err} !== 3'b100 || rsp_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL t1_rd_rsp got %b %h exp 100 deadbeef", {rsp_valid, rsp_write, rsp_err}, rsp_rdata); end
        @(negedge HCLK);
        n_chk++; if ({rsp_valid, idle} !== 2'b01) begin n_fail++; $display("FAIL t1_drain got %b exp 01", {rsp_valid, idle}); end
    endtask

    task automatic test_byte;
        use_model = 1'b0; hrdata_drv = 32'hA500_0000; q.delete();
        push(1'b1, 32'h13, 3'b000, 32'h0000_00A5);
        push(1'b0, 32'h13, 3'b000, 32'h0);
        n_chk++; if (HSIZE !== 3'b000 || HADDR !== 32'h13 || HWRITE !== 1'b1) begin n_fail++; $display("FAIL t2_addr got %b %h %b exp 000 13 1", HSIZE, HADDR, HWRITE); end
        @(negedge HCLK);
        n_chk++; if (HWDATA !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL t2_hwdata got %h exp a5a5a5a5", HWDATA); end
        repeat (4) @(negedge HCLK);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL t2_count got %0d exp 2", q.size()); end
        else begin
            n_chk++; if (q[0].w !== 1'b1 || q[0].d !== 32'd0) begin n_fail++; $display("FAIL t2_wr_rsp got %b %h exp 1 0", q[0].w, q[0].d); end
            n_chk++; if (q[1].w !== 1'b0 || q[1].d !== 32'h0000_00A5) begin n_fail++; $display("FAIL t2_rd_rsp got %b %h exp 0 a5", q[1].w, q[1].d); end
        end
    endtask

    task automatic test_align;
        use_model = 1'b0; hrdata_drv = 32'hA500_0000; q.delete();
        push(1'b0, 32'h13, 3'b001, 32'h0);
        push(1'b0, 32'h17, 3'b111, 32'h0);
        n_chk++; if (HADDR !== 32'h12 || HSIZE !== 3'b001) begin n_fail++; $display("FAIL al_half got %h %b exp 12 001", HADDR, HSIZE); end
        @(negedge HCLK);
        n_chk++; if (HADDR !== 32'h14 || HSIZE !== 3'b010) begin n_fail++; $display("FAIL al_word got %h %b exp 14 010", HADDR, HSIZE); end
        repeat (4) @(negedge HCLK);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL al_count got %0d exp 2", q.size()); end
        else begin
            n_chk++; if (q[0].d !== 32'h0000_A500) begin n_fail++; $display("FAIL al_half_data got %h exp 0000a500", q[0].d); end
            n_chk++; if (q[1].d !== 32'hA500_0000) begin n_fail++; $display("FAIL al_word_data got %h exp a5000000", q[1].d); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] h0;
        use_model = 1'b1; q.delete();
        for (int i = 0; i < 4; i++) push(1'b0, 32'(4 * i), 3'b010, 32'h0);
        // Second read is now in its data phase, third in its address phase
        HREADY = 1'b0; h0 = HWDATA;
        n_chk++; if (HADDR !== 32'h8) begin n_fail++; $display("FAIL t3_addr got %h exp 8", HADDR); end
        repeat (2) begin
            @(negedge HCLK);
            n_chk++; if (HADDR !== 32'h8 || HWDATA !== h0) begin n_fail++; $display("FAIL t3_hold got %h %h exp 8 %h", HADDR, HWDATA, h0); end
        end
        n_chk++; if (q.size() != 1) begin n_fail++; $display("FAIL t3_stall_rsp got %0d exp 1", q.size()); end
        HREADY = 1'b1;
        repeat (6) @(negedge HCLK);
        n_chk++; if (q.size() != 4) begin n_fail++; $display("FAIL t3_count got %0d exp 4", q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if (i >= q.size() || q[i].d !== (32'h5A00_0000 | 32'(4 * i)) || q[i].w !== 1'b0 || q[i].e !== 1'b0) begin
                n_fail++; $display("FAIL t3_rsp%0d got %h exp %h", i, (i < q.size()) ? q[i].d : 32'hFFFF_FFFF, 32'h5A00_0000 | 32'(4 * i));
            end
        end
    endtask

    task automatic test_fifo_full;
        use_model = 1'b1; q.delete();
        push(1'b0, 32'h100, 3'b010, 32'h0);
        @(negedge HCLK);
        HREADY = 1'b0;
        for (int i = 1; i < 5; i++) begin
            push(1'b0, 32'h100 + 32'(4 * i), 3'b010, 32'h0);
            n_chk++; if (cmd_ready !== (i < 4)) begin n_fail++; $display("FAIL t4_ready%0d got %b exp %b", i, cmd_ready, i < 4); end
        end
        cmd_valid = 1'b1; cmd_addr = 32'h114;
        repeat (2) begin
            @(negedge HCLK);
            n_chk++; if (cmd_ready !== 1'b0 || HADDR !== 32'h100) begin n_fail++; $display("FAIL t4_full got %b %h exp 0 100", cmd_ready, HADDR); end
        end
        cmd_valid = 1'b0; HREADY = 1'b1;
        n_chk++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL t4_pop_ready got %b exp 0", cmd_ready); end
        @(negedge HCLK);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL t4_after_pop got %b exp 1", cmd_ready); end
        repeat (10) @(negedge HCLK);
        n_chk++; if (q.size() != 5) begin n_fail++; $display("FAIL t4_count got %0d exp 5", q.size()); end
        for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (i >= q.size() || q[i].d !== (32'h5A00_0100 + 32'(4 * i))) begin
                n_fail++; $display("FAIL t4_rsp%0d got %h exp %h", i, (i < q.size()) ? q[i].d : 32'hFFFF_FFFF, 32'h5A00_0100 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_error;
        use_model = 1'b1; q.delete();
        push(1'b1, 32'h20, 3'b010, 32'h1234_5678);
        push(1'b0, 32'h24, 3'b010, 32'h0);
        @(negedge HCLK);
        HREADY = 1'b0; HRESP = 1'b1;
        @(negedge HCLK);
        HREADY = 1'b1;
        @(negedge HCLK);
        HRESP = 1'b0;
        repeat (4) @(negedge HCLK);
        n_chk++; if (q.size() != 2) begin n_fail++; $display("FAIL t5_count got %0d exp 2", q.size()); end
        else begin
            n_chk++; if (q[0].w !== 1'b1 || q[0].e !== 1'b1) begin n_fail++; $display("FAIL t5_wr_err got w%b e%b exp w1 e1", q[0].w, q[0].e); end
            n_chk++; if (q[1].w !== 1'b0 || q[1].e !== 1'b0 || q[1].d !== 32'h5A00_0024) begin n_fail++; $display("FAIL t5_rd got e%b %h exp e0 5a000024", q[1].e, q[1].d); end
        end
    endtask

    task automatic test_seq;
        logic [1:0] exp_b;
        logic [2:0] exp_burst;
`ifdef AHB_MASTER_SEQ_EN
        exp_b = 2'b11; exp_burst = 3'b001;
`else
        exp_b = 2'b10; exp_burst = 3'b000;
`endif
        use_model = 1'b1;
        push(1'b0, 32'h3F8, 3'b010, 32'h0);
        push(1'b0, 32'h3FC, 3'b010, 32'h0);
        n_chk++; if (HTRANS !== 2'b10 || HBURST !== exp_burst) begin n_fail++; $display("FAIL seq_a got %b %b exp 10 %b", HTRANS, HBURST, exp_burst); end
        push(1'b0, 32'h400, 3'b010, 32'h0);
        n_chk++; if (HTRANS !== exp_b) begin n_fail++; $display("FAIL seq_b got %b exp %b", HTRANS, exp_b); end
        @(negedge HCLK);
        n_chk++; if (HTRANS !== 2'b10 || HADDR !== 32'h400) begin n_fail++; $display("FAIL seq_c got %b %h exp 10 400", HTRANS, HADDR); end
        repeat (5) @(negedge HCLK);
    endtask

    task automatic test_reset_mid;
        use_model = 1'b1; q.delete();
        push(1'b0, 32'h30, 3'b010, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESET = 1'b1;
        #1;
        n_chk++; if (HTRANS !== 2'b00 || idle !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL t6_async got %b %b %b exp 00 1 0", HTRANS, idle, rsp_valid); end
        @(negedge HCLK);
        HRESET = 1'b0;
        repeat (3) @(negedge HCLK);
        n_chk++; if (q.size() != 0 || idle !== 1'b1) begin n_fail++; $display("FAIL t6_no_rsp got %0d idle %b exp 0 1", q.size(), idle); end
    endtask

    initial begin
        test_reset();
        test_word_wr_rd();
        test_byte();
        test_align();
        test_back_to_back();
        test_fifo_full();
        test_error();
        test_seq();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
